// File: rtl/dot_matrix_scroll_ctrl.sv
// dot_matrix_scroll_ctrl: column-scan sequencer and scroll scheduler for a
// 5x7 dot-matrix display.
//
// The message is held in a writable buffer of MSG_DEPTH glyph columns. A
// 5-column window slides through the message while the five display columns
// are scanned in turn. The scroll is controlled by start and stop pulses.
//
// Ports:
//   clk, reset      system clock; synchronous, active-high reset
//   wr_en/addr/data column buffer write port (bit6 = top row)
//   msg_len         number of message columns, legal range 5..MSG_DEPTH
//   start, stop     run/resume and hold/stop pulses; stop wins when both are high
//   mode            0 = step 1 column, 1 = step 5 columns
//   busy, done      busy is high in RUN or HOLD; done pulses when the window wraps
//   portA, portB    matrix buffer direction
//   col             column select, one-cold and active-low
//   row             row data, active-high
//
// Optional build macro: DOT_MATRIX_GHOST_BLANK_EN. When it is defined, row is
// blanked for the first 16 clocks of each column slot.
module dot_matrix_scroll_ctrl #(
  parameter int CLK_PER_COL = 5400,
  parameter int STEP_TICKS  = 5000,
  parameter int MSG_DEPTH   = 64,
  parameter int ADDR_W      = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [6:0]        wr_data,
  input  logic [ADDR_W:0]   msg_len,
  input  logic              start,
  input  logic              stop,
  input  logic              mode,
  output logic              busy,
  output logic              done,
  output logic [1:0]        portA,
  output logic [1:0]        portB,
  output logic [4:0]        col,
  output logic [6:0]        row
);

  localparam int SCW = $clog2(CLK_PER_COL + 1);
  localparam int STW = $clog2(STEP_TICKS + 1);
  localparam int LW  = ADDR_W + 1;
  localparam int XW  = ADDR_W + 2;

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  state_t            state;
  logic [SCW-1:0]    scan_cnt;
  logic [STW-1:0]    step_cnt;
  logic [ADDR_W-1:0] base;
  logic [LW-1:0]     len_q;
  logic              mode_q;
  logic [6:0]        mem [MSG_DEPTH];

  logic              scan_tick;
  logic              step_last;
  logic              len_ok;
  logic              blank;
  logic [2:0]        k;
  logic              k_vld;
  logic [XW-1:0]     win;
  logic [XW-1:0]     rd_full;
  logic [XW-1:0]     nxt;
  logic [XW-1:0]     nxt_red;
  logic              wrap;
  logic [ADDR_W-1:0] rd_idx;
  logic [ADDR_W-1:0] base_nxt;

  assign scan_tick = (scan_cnt == SCW'(CLK_PER_COL - 1));
  assign step_last = (step_cnt == STW'(STEP_TICKS - 1));
  assign len_ok    = (msg_len >= LW'(5)) && (msg_len <= LW'(MSG_DEPTH));

`ifdef DOT_MATRIX_GHOST_BLANK_EN
  assign blank = (32'(scan_cnt) < 32'd16);
`else
  assign blank = 1'b0;
`endif

  // Column index from the position of the zero bit in col.
  always_comb begin
    k     = 3'd0;
    k_vld = 1'b1;
    unique case (col)
      5'b11110: k = 3'd0;
      5'b11101: k = 3'd1;
      5'b11011: k = 3'd2;
      5'b10111: k = 3'd3;
      5'b01111: k = 3'd4;
      default:  k_vld = 1'b0;
    endcase
  end

  // base < len_q and k <= 4 < len_q, so one subtraction is enough to wrap.
  assign win     = XW'(base) + XW'(k);
  assign rd_full = (win >= XW'(len_q)) ? win - XW'(len_q) : win;
  assign rd_idx  = rd_full[ADDR_W-1:0];

  assign nxt      = XW'(base) + (mode_q ? XW'(5) : XW'(1));
  assign wrap     = (nxt >= XW'(len_q));
  assign nxt_red  = wrap ? nxt - XW'(len_q) : nxt;
  assign base_nxt = nxt_red[ADDR_W-1:0];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      portA    <= 2'b00;
      portB    <= 2'b00;
      col      <= 5'b11111;
      row      <= 7'd0;
      scan_cnt <= '0;
      step_cnt <= '0;
      base     <= '0;
      len_q    <= '0;
      mode_q   <= 1'b0;
    end else begin
      portA    <= 2'b01;
      portB    <= 2'b01;
      done     <= 1'b0;
      scan_cnt <= scan_tick ? '0 : scan_cnt + SCW'(1);
      if (scan_tick)
        col <= (col == 5'b11111) ? 5'b11110 : {col[3:0], col[4]};
      row <= (state != IDLE && k_vld && !blank) ? mem[rd_idx] : 7'd0;
      unique case (state)
        IDLE: begin
          if (start && !stop && len_ok) begin
            state    <= RUN;
            busy     <= 1'b1;
            len_q    <= msg_len;
            mode_q   <= mode;
            base     <= '0;
            step_cnt <= '0;
          end
        end
        RUN: begin
          if (scan_tick) begin
            if (step_last) begin
              step_cnt <= '0;
              base     <= base_nxt;
              done     <= wrap;
            end else begin
              step_cnt <= step_cnt + STW'(1);
            end
          end
          if (stop) state <= HOLD;
        end
        HOLD: begin
          if (stop) begin
            state <= IDLE;
            busy  <= 1'b0;
            base  <= '0;
          end else if (start) begin
            state <= RUN;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dot_matrix_scroll_ctrl.sv
// tb_dot_matrix_scroll_ctrl: self-checking bench for dot_matrix_scroll_ctrl.
// A behavioural model built on integer arithmetic is checked against the DUT on every cycle, together with directed literal checks.
module tb_dot_matrix_scroll_ctrl;

  localparam int CPC = 4;
  localparam int ST  = 2;
  localparam int AW  = 6;

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [6:0]    wr_data;
  logic [AW:0]   msg_len;
  logic          start;
  logic          stop;
  logic          mode;
  logic          busy;
  logic          done;
  logic [1:0]    portA;
  logic [1:0]    portB;
  logic [4:0]    col;
  logic [6:0]    row;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;

  dot_matrix_scroll_ctrl #(
    .CLK_PER_COL(CPC),
    .STEP_TICKS(ST),
    .MSG_DEPTH(64),
    .ADDR_W(AW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .msg_len(msg_len),
    .start(start),
    .stop(stop),
    .mode(mode),
    .busy(busy),
    .done(done),
    .portA(portA),
    .portB(portB),
    .col(col),
    .row(row)
  );

  always #5 clk = ~clk;

  // Behavioural model. m_k = -1 means that no column is selected yet.
  logic       mdl_on = 1'b0;
  int         m_cnt, m_k, m_st, m_base, m_step, m_len, m_mode;
  logic [6:0] m_buf [64] = '{default: 7'd0};
  logic [6:0] m_row;
  logic       m_done;
  logic [1:0] m_port;

  always @(posedge clk) begin
    int s;
    logic [6:0] n_row;
    bit t;
    if (reset) begin
      mdl_on = 1'b1;
      m_cnt = 0; m_k = -1; m_st = 0; m_base = 0; m_step = 0;
      m_len = 0; m_mode = 0;
      m_row = 7'd0; m_done = 1'b0; m_port = 2'b00;
    end else begin
      t = (m_cnt == CPC - 1);
      n_row = (m_st != 0 && m_k >= 0) ? m_buf[(m_base + m_k) % m_len] : 7'd0;
      if (wr_en) m_buf[wr_addr] = wr_data;
      m_done = 1'b0;
      m_port = 2'b01;
      case (m_st)
        0: if (start && !stop && msg_len >= 5 && msg_len <= 64) begin
          m_st = 1; m_len = int'(msg_len); m_mode = int'(mode);
          m_base = 0; m_step = 0;
        end
        1: begin
          if (t) begin
            if (m_step == ST - 1) begin
              m_step = 0;
              s = m_mode ? 5 : 1;
              if (m_base + s >= m_len) m_done = 1'b1;
              m_base = (m_base + s) % m_len;
            end else begin
              m_step++;
            end
          end
          if (stop) m_st = 2;
        end
        default: begin
          if (stop) begin m_st = 0; m_base = 0; end
          else if (start) m_st = 1;
        end
      endcase
      if (t) m_k = (m_k + 1) % 5;
      m_cnt = (m_cnt + 1) % CPC;
      m_row = n_row;
    end
  end

  logic [4:0] ecol;
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (mdl_on) begin
      ecol = (m_k < 0) ? 5'b11111 : ~(5'(1) << m_k);
      checks++;
      if (col !== ecol || row !== m_row || busy !== (m_st != 0) ||
          done !== m_done || portA !== m_port || portB !== m_port) begin
        errors++;
        $display("FAIL model t=%0t col=%b/%b row=%h/%h busy=%b/%b done=%b/%b ports=%b,%b/%b",
                 $time, col, ecol, row, m_row, busy, (m_st != 0), done, m_done,
                 portA, portB, m_port);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic pulse_start;
    start = 1'b1; tick(1); start = 1'b0;
  endtask

  task automatic pulse_stop;
    stop = 1'b1; tick(1); stop = 1'b0;
  endtask

  // One start edge, then 8 RUN edges (two scan ticks, so one step), then
  // stop. The window ends up held and advanced by exactly one step.
  task automatic run8;
    pulse_start; tick(7); pulse_stop;
  endtask

  task automatic show_window(input string nm, input int e0, input int e1,
                             input int e2, input int e3, input int e4);
    int e [5];
    e = '{e0, e1, e2, e3, e4};
    for (int k = 0; k < 5; k++) begin
      logic [4:0] want;
      int n;
      want = ~(5'(1) << k);
      n = 0;
      while (col !== want && n < 40) begin tick(1); n++; end
      chk($sformatf("%s col%0d reached", nm, k), int'(col), int'(want));
      tick(1);
      chk($sformatf("%s row k=%0d", nm, k), int'(row), e[k]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    msg_len = 7'd10; start = 1'b0; stop = 1'b0; mode = 1'b0;

    // 1: reset, then port and column start-up
    tick(3);
    chk("rst col", int'(col), 31);
    chk("rst row", int'(row), 0);
    chk("rst busy", int'(busy), 0);
    chk("rst portA", int'(portA), 0);
    reset = 1'b0;
    tick(1);
    chk("portA after release", int'(portA), 1);
    chk("portB after release", int'(portB), 1);
    chk("col clk1", int'(col), 31);
    tick(2);
    chk("col clk3", int'(col), 31);
    tick(1);
    chk("col clk4", int'(col), 30);

    // 2: load 1..10 and scroll by 1
    for (int i = 0; i < 10; i++) begin
      wr_en = 1'b1; wr_addr = AW'(i); wr_data = 7'(i + 1); tick(1);
    end
    wr_en = 1'b0;
    msg_len = 7'd10; mode = 1'b0;
    pulse_start;
    chk("busy run", int'(busy), 1);
    pulse_stop;
    chk("busy hold", int'(busy), 1);
    done_cnt = 0;
    show_window("base0", 1, 2, 3, 4, 5);
    run8;
    show_window("base1", 2, 3, 4, 5, 6);

    // 5: hold freezes base, resume, stop twice -> idle
    tick(80);
    chk("busy held", int'(busy), 1);
    show_window("frozen", 2, 3, 4, 5, 6);
    run8;
    show_window("resumed", 3, 4, 5, 6, 7);
    chk("no done len10", done_cnt, 0);
    pulse_stop;
    chk("busy idle", int'(busy), 0);
    tick(1);
    chk("row idle", int'(row), 0);

    // 3: glyph mode, wrap 5 -> 0
    mode = 1'b1;
    pulse_start; pulse_stop;
    run8;
    show_window("g5", 6, 7, 8, 9, 10);
    chk("done before wrap", done_cnt, 0);
    run8;
    show_window("g0", 1, 2, 3, 4, 5);
    chk("done at wrap", done_cnt, 1);
    pulse_stop;

    // 4: length 7, wrap modulo 7
    mode = 1'b0; msg_len = 7'd7; done_cnt = 0;
    pulse_start; pulse_stop;
    repeat (5) run8;
    show_window("l7b5", 6, 7, 1, 2, 3);
    chk("l7 no done to 5", done_cnt, 0);
    run8;
    show_window("l7b6", 7, 1, 2, 3, 4);
    chk("l7 no done 5to6", done_cnt, 0);
    run8;
    show_window("l7b0", 1, 2, 3, 4, 5);
    chk("l7 done 6to0", done_cnt, 1);
    pulse_stop;

    // 6: start+stop together, illegal length, boundaries, writes, reset
    msg_len = 7'd10;
    start = 1'b1; stop = 1'b1; tick(1); start = 1'b0; stop = 1'b0;
    tick(1);
    chk("both in idle", int'(busy), 0);
    pulse_start;
    chk("run again", int'(busy), 1);
    start = 1'b1; stop = 1'b1; tick(1); start = 1'b0; stop = 1'b0;
    chk("both in run", int'(busy), 1);
    tick(20);
    start = 1'b1; stop = 1'b1; tick(1); start = 1'b0; stop = 1'b0;
    chk("both in hold", int'(busy), 0);
    msg_len = 7'd4; pulse_start;
    chk("len4 ignored", int'(busy), 0);
    msg_len = 7'd65; pulse_start;
    chk("len65 ignored", int'(busy), 0);
    msg_len = 7'd5; pulse_start;
    chk("len5 accepted", int'(busy), 1);
    pulse_stop; pulse_stop;
    msg_len = 7'd64; pulse_start;
    chk("len64 accepted", int'(busy), 1);
    pulse_stop; pulse_stop;
    msg_len = 7'd10;
    pulse_start; pulse_stop;
    wr_en = 1'b1; wr_addr = AW'(2); wr_data = 7'h55; tick(1); wr_en = 1'b0;
    show_window("written", 1, 2, 'h55, 4, 5);
    pulse_start;
    tick(3);
    reset = 1'b1;
    tick(1);
    chk("midrun rst col", int'(col), 31);
    chk("midrun rst row", int'(row), 0);
    chk("midrun rst busy", int'(busy), 0);
    chk("midrun rst done", int'(done), 0);
    chk("midrun rst portA", int'(portA), 0);
    reset = 1'b0;
    tick(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
